// File: rtl/paper_dispenser_pkg.sv
// Shared types and widths for the paper dispenser slice.
package paper_pkg;

  localparam int unsigned STOCK_W = 8;
  localparam int unsigned PEND_W  = 2;
  localparam int unsigned TMR_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    FAULT
  } state_t;

endpackage

// File: rtl/paper_dispenser_if.sv
// Request/sensor/status bundle between the vending FSM side and the dispenser.
interface paper_dispenser_if;
  import paper_pkg::*;

  logic               newspaper;
  logic               drop_sensor;
  logic               refill;
  logic               motor;
  logic               busy;
  logic               empty;
  logic               fault;
  logic               lost;
  logic [STOCK_W-1:0] stock;
  logic [PEND_W-1:0]  pending;

  modport master (
    output newspaper, drop_sensor, refill,
    input  motor, busy, empty, fault, lost, stock, pending
  );

  modport slave (
    input  newspaper, drop_sensor, refill,
    output motor, busy, empty, fault, lost, stock, pending
  );

endinterface

// File: rtl/paper_dispenser_timer.sv
// Loadable down-counter; done flags the last cycle of the loaded interval.
module disp_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/paper_dispenser.sv
// Vend queue, motor/drop FSM and stock tracking behind the newspaper vending FSM.
module paper_dispenser
  import paper_pkg::*;
#(
  parameter int unsigned STOCK_INIT     = 3,
  parameter int unsigned MOTOR_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned QUEUE_DEPTH    = 3
) (
  input logic               clk,
  input logic               rst,
  paper_dispenser_if.slave  bus
);

  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);
  localparam logic [PEND_W-1:0]  QMAX      = PEND_W'(QUEUE_DEPTH);

  state_t             state, state_nx;
  logic [PEND_W-1:0]  pending, pending_nx;
  logic [STOCK_W-1:0] stock, stock_nx;
  logic               motor, busy, empty, fault, lost;

  logic               tmr_load, tmr_done;
  logic [TMR_W-1:0]   tmr_val;
  logic               deq, accept, stock_dec, stock_load;

  disp_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_nx   = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    deq        = 1'b0;
    stock_dec  = 1'b0;
    stock_load = 1'b0;
    case (state)
      IDLE: begin
        if (bus.refill) begin
          stock_load = 1'b1;
        end else if (pending != '0 && stock != '0) begin
          state_nx = RUN;
          deq      = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(MOTOR_CYCLES);
        end
      end
      RUN: begin
        if (bus.drop_sensor) begin
          stock_dec = 1'b1;
          state_nx  = IDLE;
        end else if (tmr_done) begin
          state_nx = WAIT;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYCLES);
        end
      end
      WAIT: begin
        if (bus.drop_sensor) begin
          stock_dec = 1'b1;
          state_nx  = IDLE;
        end else if (tmr_done) begin
          state_nx = FAULT;
        end
      end
      default: state_nx = FAULT;
    endcase
  end

  // A simultaneous dequeue frees the slot, so a request at a full queue is still taken.
  always_comb begin
    accept = bus.newspaper && (state != FAULT) && ((pending < QMAX) || deq);
    case ({accept, deq})
      2'b10:   pending_nx = pending + PEND_W'(1);
      2'b01:   pending_nx = pending - PEND_W'(1);
      default: pending_nx = pending;
    endcase
    if (stock_load) begin
      stock_nx = STOCK_RST;
    end else if (stock_dec && stock != '0) begin
      stock_nx = stock - STOCK_W'(1);
    end else begin
      stock_nx = stock;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      motor   <= 1'b0;
      busy    <= 1'b0;
      fault   <= 1'b0;
      lost    <= 1'b0;
      pending <= '0;
      stock   <= STOCK_RST;
      empty   <= (STOCK_RST == '0);
    end else begin
      state   <= state_nx;
      motor   <= (state_nx == RUN);
      busy    <= (state_nx == RUN) || (state_nx == WAIT);
      fault   <= (state_nx == FAULT);
      lost    <= bus.newspaper && !accept;
      pending <= pending_nx;
      stock   <= stock_nx;
      empty   <= (stock_nx == '0);
    end
  end

  assign bus.motor   = motor;
  assign bus.busy    = busy;
  assign bus.empty   = empty;
  assign bus.fault   = fault;
  assign bus.lost    = lost;
  assign bus.stock   = stock;
  assign bus.pending = pending;

endmodule

// File: tb/tb_paper_dispenser.sv
// Directed bench for paper_dispenser with default parameters.
module tb_paper_dispenser;
  import paper_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  paper_dispenser_if bus();

  paper_dispenser #(
    .STOCK_INIT     (3),
    .MOTOR_CYCLES   (4),
    .TIMEOUT_CYCLES (16),
    .QUEUE_DEPTH    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.newspaper = 1'b0;
    bus.drop_sensor = 1'b0;
    bus.refill = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_in_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy === 1'b1 && bus.motor === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Waits for a vend to reach WAIT, acks it with a one-cycle drop, ends one cycle after the drop.
  task automatic vend_drop(output bit ok);
    bit a, b;
    b = 1'b0;
    wait_busy(a);
    if (a) wait_in_wait(b);
    if (a && b) begin
      bus.drop_sensor = 1'b1;
      tick();
      bus.drop_sensor = 1'b0;
    end
    ok = a && b;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.motor !== 1'b0) begin bad++; $display("FAIL reset_motor: got %b expected 0", bus.motor); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
    total++; if (bus.lost !== 1'b0) begin bad++; $display("FAIL reset_lost: got %b expected 0", bus.lost); end
    total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL reset_pending: got %0d expected 0", bus.pending); end
    total++; if (bus.stock !== 8'd3) begin bad++; $display("FAIL reset_stock: got %0d expected 3", bus.stock); end
    total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL reset_empty: got %b expected 0", bus.empty); end
  endtask

  task automatic test_single_vend();
    do_reset();
    bus.newspaper = 1'b1;
    tick();
    bus.newspaper = 1'b0;
    total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL single_pending_t1: got %0d expected 1", bus.pending); end
    total++; if (bus.motor !== 1'b0) begin bad++; $display("FAIL single_motor_t1: got %b expected 0", bus.motor); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      total++; if (bus.motor !== 1'b1) begin bad++; $display("FAIL single_motor_t%0d: got %b expected 1", k, bus.motor); end
    end
    total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL single_pending_run: got %0d expected 0", bus.pending); end
    tick();
    total++; if (bus.motor !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_wait_entry: got motor=%b busy=%b expected motor=0 busy=1", bus.motor, bus.busy); end
    tick();
    tick();
    bus.drop_sensor = 1'b1;
    tick();
    bus.drop_sensor = 1'b0;
    total++; if (bus.stock !== 8'd2) begin bad++; $display("FAIL single_stock: got %0d expected 2", bus.stock); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b expected 0", bus.busy); end
    total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL single_pending_after: got %0d expected 0", bus.pending); end
    tick();
    total++; if (bus.busy !== 1'b0 || bus.stock !== 8'd2) begin bad++; $display("FAIL single_settle: got busy=%b stock=%0d expected busy=0 stock=2", bus.busy, bus.stock); end
  endtask

  task automatic test_burst();
    int  lost_cnt;
    bit  ok;
    do_reset();
    lost_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus.newspaper = 1'b1;
      tick();
      if (bus.lost === 1'b1) lost_cnt++;
    end
    bus.newspaper = 1'b0;
    total++; if (bus.pending !== 2'd3) begin bad++; $display("FAIL burst_pending_full: got %0d expected 3", bus.pending); end
    tick();
    if (bus.lost === 1'b1) lost_cnt++;
    total++; if (lost_cnt !== 1) begin bad++; $display("FAIL burst_lost_count: got %0d expected 1", lost_cnt); end
    for (int v = 0; v < 3; v++) begin
      vend_drop(ok);
      total++; if (!ok) begin bad++; $display("FAIL burst_vend%0d_timeout: got 0 expected 1", v); end
      total++; if (bus.stock !== 8'(2 - v)) begin bad++; $display("FAIL burst_stock_v%0d: got %0d expected %0d", v, bus.stock, 2 - v); end
    end
    for (int i = 0; i < 4; i++) tick();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL burst_empty: got %b expected 1", bus.empty); end
    total++; if (bus.motor !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL burst_idle_empty: got motor=%b busy=%b expected 0 0", bus.motor, bus.busy); end
    total++; if (bus.pending !== 2'd1) begin bad++; $display("FAIL burst_pending_left: got %0d expected 1", bus.pending); end
  endtask

  task automatic test_empty_queue();
    bit ok;
    do_reset();
    for (int v = 0; v < 3; v++) begin
      bus.newspaper = 1'b1;
      tick();
      bus.newspaper = 1'b0;
      vend_drop(ok);
      total++; if (!ok) begin bad++; $display("FAIL emptyq_setup%0d_timeout: got 0 expected 1", v); end
    end
    total++; if (bus.stock !== 8'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL emptyq_drained: got stock=%0d empty=%b expected 0 1", bus.stock, bus.empty); end
    bus.newspaper = 1'b1;
    tick();
    tick();
    bus.newspaper = 1'b0;
    total++; if (bus.pending !== 2'd2) begin bad++; $display("FAIL emptyq_pending: got %0d expected 2", bus.pending); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (bus.motor !== 1'b0) begin bad++; $display("FAIL emptyq_motor_idle%0d: got %b expected 0", i, bus.motor); end
    end
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
    total++; if (bus.stock !== 8'd3 || bus.busy !== 1'b0) begin bad++; $display("FAIL emptyq_refill: got stock=%0d busy=%b expected 3 0", bus.stock, bus.busy); end
    for (int v = 0; v < 2; v++) begin
      vend_drop(ok);
      total++; if (!ok) begin bad++; $display("FAIL emptyq_vend%0d_timeout: got 0 expected 1", v); end
    end
    total++; if (bus.stock !== 8'd1) begin bad++; $display("FAIL emptyq_stock_end: got %0d expected 1", bus.stock); end
    total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL emptyq_pending_end: got %0d expected 0", bus.pending); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.newspaper = 1'b1;
    tick();
    bus.newspaper = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (bus.busy !== 1'b1 || bus.motor !== 1'b0) begin bad++; $display("FAIL timeout_wait_entry: got busy=%b motor=%b expected 1 0", bus.busy, bus.motor); end
    for (int i = 0; i < 15; i++) tick();
    total++; if (bus.fault !== 1'b0) begin bad++; $display("FAIL timeout_early: got fault=%b expected 0", bus.fault); end
    tick();
    total++; if (bus.fault !== 1'b1) begin bad++; $display("FAIL timeout_fault: got %b expected 1", bus.fault); end
    total++; if (bus.motor !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_outputs: got motor=%b busy=%b expected 0 0", bus.motor, bus.busy); end
    bus.newspaper = 1'b1;
    tick();
    bus.newspaper = 1'b0;
    total++; if (bus.lost !== 1'b1) begin bad++; $display("FAIL fault_lost: got %b expected 1", bus.lost); end
    total++; if (bus.pending !== 2'd0) begin bad++; $display("FAIL fault_pending: got %0d expected 0", bus.pending); end
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
    total++; if (bus.lost !== 1'b0) begin bad++; $display("FAIL fault_lost_clear: got %b expected 0", bus.lost); end
    total++; if (bus.stock !== 8'd3 || bus.fault !== 1'b1) begin bad++; $display("FAIL fault_refill_ignored: got stock=%0d fault=%b expected 3 1", bus.stock, bus.fault); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.fault !== 1'b0 || bus.stock !== 8'd3 || bus.pending !== 2'd0) begin bad++; $display("FAIL fault_rst_clear: got fault=%b stock=%0d pending=%0d expected 0 3 0", bus.fault, bus.stock, bus.pending); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    bus.newspaper = 1'b1;
    tick();
    tick();
    bus.newspaper = 1'b0;
    total++; if (bus.motor !== 1'b1 || bus.pending !== 2'd1) begin bad++; $display("FAIL midrun_setup: got motor=%b pending=%0d expected 1 1", bus.motor, bus.pending); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.motor !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrun_rst_motor: got motor=%b busy=%b expected 0 0", bus.motor, bus.busy); end
    total++; if (bus.pending !== 2'd0 || bus.stock !== 8'd3) begin bad++; $display("FAIL midrun_rst_counts: got pending=%0d stock=%0d expected 0 3", bus.pending, bus.stock); end
    tick();
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrun_no_restart: got busy=%b expected 0", bus.busy); end
  endtask

  task automatic test_refill_collision();
    bit ok;
    do_reset();
    bus.newspaper = 1'b1;
    tick();
    bus.newspaper = 1'b0;
    vend_drop(ok);
    total++; if (!ok || bus.stock !== 8'd2) begin bad++; $display("FAIL collide_setup: got ok=%b stock=%0d expected 1 2", ok, bus.stock); end
    bus.newspaper = 1'b1;
    tick();
    bus.newspaper = 1'b0;
    bus.refill = 1'b1;
    tick();
    bus.refill = 1'b0;
    total++; if (bus.stock !== 8'd3) begin bad++; $display("FAIL collide_stock: got %0d expected 3", bus.stock); end
    total++; if (bus.busy !== 1'b0 || bus.pending !== 2'd1) begin bad++; $display("FAIL collide_no_start: got busy=%b pending=%0d expected 0 1", bus.busy, bus.pending); end
    tick();
    total++; if (bus.motor !== 1'b1 || bus.pending !== 2'd0) begin bad++; $display("FAIL collide_run: got motor=%b pending=%0d expected 1 0", bus.motor, bus.pending); end
    vend_drop(ok);
    total++; if (!ok || bus.stock !== 8'd2) begin bad++; $display("FAIL collide_vend: got ok=%b stock=%0d expected 1 2", ok, bus.stock); end
  endtask

  initial begin
    bus.newspaper = 1'b0;
    bus.drop_sensor = 1'b0;
    bus.refill = 1'b0;
    test_reset();
    test_single_vend();
    test_burst();
    test_empty_queue();
    test_timeout();
    test_reset_mid_run();
    test_refill_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
